frog_game_core: RTL and testbench

FROG_GAME_CORE -- requirements
Module: frog_game_core

---
 rtl/frog_game_core.sv | 197 +++++++++++++++++++
 tb/tb_frog_game_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_game_core.sv
// Game-state core for a frog-dodges-falling-objects game: player motion, obstacle
// fall/respawn, collision latch, lives/score bookkeeping and the IDLE/PLAY/DYING/OVER FSM.
module frog_game_core #(
  parameter int                CORDW      = 16,
  parameter int                OBJ_CNT    = 5,
  parameter int                LFSR_W     = 9,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 9'b101110010,
  parameter int                H_RES      = 640,
  parameter int                SPR_DRAWW  = 64,
  parameter int                GROUND_Y   = 245,
  parameter int                APEX_Y     = 180,
  parameter int                FALL_Y     = 230,
  parameter int                RESPAWN_Y  = -300,
  parameter int                FROG_X0    = 120,
  parameter int                SPX        = 2,
  parameter int                OBJ_SPY    = 2,
  parameter int                OBJ_X0     = 158,
  parameter int                OBJ_XSTEP  = 64,
  parameter int                OBJ_Y0     = -200,
  parameter int                OBJ_YSTEP  = 50,
  parameter int                LIVES      = 3,
  parameter int                DIE_FRAMES = 60
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix,
  input  logic                       frame,
  input  logic                       de,
  input  logic                       frog_pix,
  input  logic [OBJ_CNT-1:0]         obj_pix,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_up,
  input  logic                       btn_start,
  output logic signed [CORDW-1:0]    frog_x,
  output logic signed [CORDW-1:0]    frog_y,
  output logic [OBJ_CNT*CORDW-1:0]   obj_x,
  output logic [OBJ_CNT*CORDW-1:0]   obj_y,
  output logic [15:0]                score,
  output logic [3:0]                 lives,
  output logic [1:0]                 state,
  output logic                       hit_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;

  localparam int DW = $clog2(DIE_FRAMES + 1);
  localparam logic signed [CORDW-1:0] GROUND_C = CORDW'(GROUND_Y);
  localparam logic signed [CORDW-1:0] APEX_C   = CORDW'(APEX_Y);
  localparam logic signed [CORDW-1:0] FALL_C   = CORDW'(FALL_Y);
  localparam logic signed [CORDW-1:0] RESP_C   = CORDW'(RESPAWN_Y);
  localparam logic signed [CORDW-1:0] FROG_X_C = CORDW'(FROG_X0);
  localparam logic signed [CORDW-1:0] X_MIN_C  = CORDW'(-SPR_DRAWW);
  localparam logic signed [CORDW-1:0] X_MAX_C  = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] SPX_C    = CORDW'(SPX);
  localparam logic signed [CORDW-1:0] SPY_C    = CORDW'(OBJ_SPY);
  localparam logic signed [CORDW-1:0] JUMP_C   = CORDW'(2);
  localparam logic signed [CORDW-1:0] SINK_C   = CORDW'(1);
  localparam logic [3:0]              LIVES_C  = 4'(LIVES);

  function automatic logic signed [CORDW-1:0] start_ox(input int i);
    return CORDW'(OBJ_X0 + i * OBJ_XSTEP);
  endfunction

  function automatic logic signed [CORDW-1:0] start_oy(input int i);
    return CORDW'(OBJ_Y0 - i * OBJ_YSTEP);
  endfunction

  state_t                   st;
  logic [LFSR_W-1:0]        lfsr, lfsr_nxt;
  logic                     hit_latch, hit_now, hit_any;
  logic                     jump, jump_nxt;
  logic [DW-1:0]            die_cnt;
  logic                     die_last, load_start, play_step, die_step;
  logic signed [CORDW-1:0]  ox [OBJ_CNT];
  logic signed [CORDW-1:0]  oy [OBJ_CNT];
  logic [OBJ_CNT-1:0]       respawn;
  logic [4:0]               resp_cnt;
  logic [16:0]              score_sum;
  logic [15:0]              score_nxt;
  logic signed [CORDW-1:0]  fx_nxt, fy_nxt;

  assign state = st;

  for (genvar g = 0; g < OBJ_CNT; g++) begin : g_flat
    assign obj_x[g*CORDW +: CORDW] = ox[g];
    assign obj_y[g*CORDW +: CORDW] = oy[g];
  end

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    hit_now  = frog_pix && (|obj_pix);
    hit_any  = hit_latch || hit_now;
    die_last = (die_cnt == DW'(DIE_FRAMES - 1));
    play_step  = frame && (st == PLAY) && !hit_any;
    die_step   = frame && (st == DYING) && !die_last;
    load_start = frame && (((st == IDLE) && btn_start) ||
                           ((st == DYING) && die_last && (lives != '0)));

    respawn  = '0;
    resp_cnt = '0;
    for (int i = 0; i < OBJ_CNT; i++) begin
      respawn[i] = (oy[i] > FALL_C);
      resp_cnt   = resp_cnt + 5'(respawn[i]);
    end
    score_sum = {1'b0, score} + 17'(resp_cnt);
    score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // Screen wrap has priority over the buttons; right wins over left.
    fx_nxt = frog_x;
    if (frog_x < X_MIN_C)       fx_nxt = X_MAX_C;
    else if (frog_x > X_MAX_C)  fx_nxt = X_MIN_C;
    else if (btn_right)         fx_nxt = frog_x + SPX_C;
    else if (btn_left)          fx_nxt = frog_x - SPX_C;

    jump_nxt = (jump && !(frog_y < APEX_C)) || (btn_up && (frog_y == GROUND_C));
    if (jump_nxt)               fy_nxt = frog_y - JUMP_C;
    else if (frog_y < GROUND_C) fy_nxt = frog_y + SINK_C;
    else                        fy_nxt = GROUND_C;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      st        <= IDLE;
      score     <= '0;
      lives     <= LIVES_C;
      hit_pulse <= 1'b0;
      hit_latch <= 1'b0;
      jump      <= 1'b0;
      die_cnt   <= '0;
      lfsr      <= '1;
      frog_x    <= FROG_X_C;
      frog_y    <= GROUND_C;
      // NOTE: object positions are a handful of flops, not a RAM, so they take the async reset too.
      for (int i = 0; i < OBJ_CNT; i++) begin
        ox[i] <= start_ox(i);
        oy[i] <= start_oy(i);
      end
    end else begin
      hit_pulse <= 1'b0;
      if (de) lfsr <= lfsr_nxt;
      if ((st == PLAY) && hit_now) hit_latch <= 1'b1;

      if (frame) begin
        case (st)
          IDLE: if (btn_start) begin
            st    <= PLAY;
            score <= '0;
            lives <= LIVES_C;
          end
          PLAY: if (hit_any) begin
            st        <= DYING;
            lives     <= (lives != '0) ? lives - 4'd1 : '0;
            hit_pulse <= 1'b1;
            hit_latch <= 1'b0;
            die_cnt   <= '0;
          end else begin
            score <= score_nxt;
          end
          DYING: if (die_last) begin
            die_cnt <= '0;
            st      <= (lives == '0) ? OVER : PLAY;
          end else begin
            die_cnt <= die_cnt + DW'(1);
          end
          OVER: if (btn_start) st <= IDLE;
          default: st <= IDLE;
        endcase
      end

      if (load_start) begin
        frog_x <= FROG_X_C;
        frog_y <= GROUND_C;
        jump   <= 1'b0;
        for (int i = 0; i < OBJ_CNT; i++) begin
          ox[i] <= start_ox(i);
          oy[i] <= start_oy(i);
        end
      end else if (play_step) begin
        frog_x <= fx_nxt;
        frog_y <= fy_nxt;
        jump   <= jump_nxt;
        for (int i = 0; i < OBJ_CNT; i++) begin
          if (respawn[i]) begin
            oy[i] <= RESP_C;
            ox[i] <= CORDW'(lfsr);
          end else begin
            oy[i] <= oy[i] + SPY_C;
          end
        end
      end else if (die_step) begin
        frog_y <= frog_y + SINK_C;
      end
    end
  end

endmodule

// File: tb/tb_frog_game_core.sv
// Directed bench for frog_game_core: movement table, jump arc, wrap, respawn/score,
// lives/DYING/OVER flow, async reset abort, and score saturation on a fast-respawn instance.
module tb_frog_game_core;

  logic clk = 1'b0;
  logic rst_pix, frame, de, frog_pix;
  logic [4:0] obj_pix;
  logic btn_left, btn_right, btn_up, btn_start;
  logic signed [15:0] frog_x, frog_y;
  logic [79:0] obj_x, obj_y;
  logic [15:0] score;
  logic [3:0] lives;
  logic [1:0] state;
  logic hit_pulse;

  logic sat_frame, sat_start;
  logic [1:0] sat_obj_pix;
  logic signed [15:0] s_frog_x, s_frog_y;
  logic [31:0] s_obj_x, s_obj_y;
  logic [15:0] s_score;
  logic [3:0] s_lives;
  logic [1:0] s_state;
  logic s_hit_pulse;

  int checks = 0;
  int errors = 0;
  logic [8:0] lfsr_m;

  always #5 clk = ~clk;

  frog_game_core dut (
    .clk_pix(clk), .rst_pix(rst_pix), .frame(frame), .de(de),
    .frog_pix(frog_pix), .obj_pix(obj_pix),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_start(btn_start),
    .frog_x(frog_x), .frog_y(frog_y), .obj_x(obj_x), .obj_y(obj_y),
    .score(score), .lives(lives), .state(state), .hit_pulse(hit_pulse)
  );

  // Every object is always below FALL_Y here, so both respawn on every frame.
  frog_game_core #(.OBJ_CNT(2), .FALL_Y(-1000)) sat_dut (
    .clk_pix(clk), .rst_pix(rst_pix), .frame(sat_frame), .de(de),
    .frog_pix(frog_pix), .obj_pix(sat_obj_pix),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_start(sat_start),
    .frog_x(s_frog_x), .frog_y(s_frog_y), .obj_x(s_obj_x), .obj_y(s_obj_y),
    .score(s_score), .lives(s_lives), .state(s_state), .hit_pulse(s_hit_pulse)
  );

  typedef struct {
    logic l;
    logic r;
    logic signed [15:0] fx;
    logic signed [15:0] fy;
    logic signed [15:0] o0y;
  } vec_t;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] lfsr_step(input logic [8:0] x);
    return {1'b0, x[8:1]} ^ (x[0] ? 9'b101110010 : 9'b000000000);
  endfunction

  function automatic logic signed [15:0] ox(input int i);
    return obj_x[i*16 +: 16];
  endfunction

  function automatic logic signed [15:0] oy(input int i);
    return obj_y[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three de cycles, then a single frame cycle carrying the buttons (and optionally a hit).
  task automatic do_frame(input logic l, input logic r, input logic u, input logic s, input logic h);
    for (int i = 0; i < 3; i++) begin
      de = 1'b1;
      tick();
      lfsr_m = lfsr_step(lfsr_m);
    end
    de = 1'b0;
    btn_left = l; btn_right = r; btn_up = u; btn_start = s;
    if (h) begin
      frog_pix = 1'b1;
      obj_pix  = 5'b00010;
    end
    frame = 1'b1;
    tick();
    frame = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_start = 1'b0;
    frog_pix = 1'b0; obj_pix = '0;
  endtask

  task automatic run_frames(input int n, input logic l, input logic r);
    for (int i = 0; i < n; i++) do_frame(l, r, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_hit();
    frog_pix = 1'b1;
    obj_pix  = 5'b00100;
    tick();
    frog_pix = 1'b0;
    obj_pix  = '0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b0, 1'b1, 16'sd122, 16'sd245, -16'sd198};
    vecs[1] = '{1'b0, 1'b1, 16'sd124, 16'sd245, -16'sd196};
    vecs[2] = '{1'b1, 1'b0, 16'sd122, 16'sd245, -16'sd194};
    vecs[3] = '{1'b1, 1'b1, 16'sd124, 16'sd245, -16'sd192};
    vecs[4] = '{1'b0, 1'b0, 16'sd124, 16'sd245, -16'sd190};
    vecs[5] = '{1'b1, 1'b0, 16'sd122, 16'sd245, -16'sd188};
    vecs[6] = '{1'b1, 1'b0, 16'sd120, 16'sd245, -16'sd186};

    rst_pix = 1'b1; frame = 1'b0; de = 1'b0; frog_pix = 1'b0; obj_pix = '0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_start = 1'b0;
    sat_frame = 1'b0; sat_start = 1'b0; sat_obj_pix = '0;
    lfsr_m = 9'h1FF;
    tick(); tick();
    rst_pix = 1'b0;

    check("rst_state", state, 0);
    check("rst_lives", lives, 3);
    check("rst_score", score, 0);
    check("rst_pulse", hit_pulse, 0);
    check("rst_frog_x", frog_x, 120);
    check("rst_frog_y", frog_y, 245);
    check("rst_obj4_x", ox(4), 414);
    check("rst_obj4_y", oy(4), -400);

    do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_hold_state", state, 0);
    check("idle_hold_obj0_y", oy(0), -200);

    // Start frame: k0
    do_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("start_state", state, 1);
    check("start_lives", lives, 3);
    check("start_score", score, 0);
    check("start_frog_x", frog_x, 120);
    check("start_frog_y", frog_y, 245);
    check("start_obj0_x", ox(0), 158);
    check("start_obj0_y", oy(0), -200);
    check("start_obj4_x", ox(4), 414);
    check("start_obj4_y", oy(4), -400);

    // Frames k1..k7
    for (int v = 0; v < 7; v++) begin
      do_frame(vecs[v].l, vecs[v].r, 1'b0, 1'b0, 1'b0);
      check("tbl_frog_x", frog_x, vecs[v].fx);
      check("tbl_frog_y", frog_y, vecs[v].fy);
      check("tbl_obj0_y", oy(0), vecs[v].o0y);
      check("tbl_state", state, 1);
      check("tbl_score", score, 0);
    end

    // Jump arc: k8 takes off, k40 first below apex, k41 descent, k106 back on ground.
    do_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("jump_first", frog_y, 243);
    run_frames(31, 1'b0, 1'b0);
    check("jump_k39", frog_y, 181);
    run_frames(1, 1'b0, 1'b0);
    check("jump_below_apex", frog_y, 179);
    run_frames(1, 1'b0, 1'b0);
    check("jump_descend", frog_y, 180);
    run_frames(65, 1'b0, 1'b0);
    check("jump_landed", frog_y, 245);
    run_frames(1, 1'b0, 1'b0);
    check("jump_ground_hold", frog_y, 245);

    // Wrap: k108..k200 left, then right frames k201..k203.
    run_frames(93, 1'b1, 1'b0);
    check("wrap_left_edge", frog_x, -66);
    run_frames(1, 1'b0, 1'b1);
    check("wrap_to_right", frog_x, 640);
    run_frames(1, 1'b0, 1'b1);
    check("wrap_at_right", frog_x, 642);
    run_frames(1, 1'b0, 1'b1);
    check("wrap_to_left", frog_x, -64);

    // Respawn: obj0 reaches 232 at k216 and respawns at k217.
    run_frames(13, 1'b0, 1'b0);
    check("pre_resp_obj0_y", oy(0), 232);
    check("pre_resp_score", score, 0);
    run_frames(1, 1'b0, 1'b0);
    check("resp_obj0_y", oy(0), -300);
    check("resp_obj0_x", ox(0), 64'(lfsr_m));
    check("resp_score", score, 1);
    check("resp_obj1_y", oy(1), 184);

    // Mid-frame hit, first death.
    pulse_hit();
    do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hit1_state", state, 2);
    check("hit1_lives", lives, 2);
    check("hit1_pulse", hit_pulse, 1);
    check("hit1_obj1_held", oy(1), 184);
    tick();
    check("hit1_pulse_end", hit_pulse, 0);

    pulse_hit();
    run_frames(59, 1'b0, 1'b0);
    check("dying_state", state, 2);
    check("dying_frog_y", frog_y, 304);
    check("dying_obj1_frozen", oy(1), 184);
    check("dying_no_pulse", hit_pulse, 0);
    run_frames(1, 1'b0, 1'b0);
    check("revive_state", state, 1);
    check("revive_frog_x", frog_x, 120);
    check("revive_frog_y", frog_y, 245);
    check("revive_obj0_x", ox(0), 158);
    check("revive_obj0_y", oy(0), -200);
    check("revive_obj4_y", oy(4), -400);
    check("revive_score", score, 1);
    check("revive_lives", lives, 2);
    run_frames(1, 1'b0, 1'b0);
    check("ignored_hit_state", state, 1);
    check("ignored_hit_obj0_y", oy(0), -198);

    // Hit on the frame cycle itself, second and third deaths.
    do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hit2_state", state, 2);
    check("hit2_lives", lives, 1);
    check("hit2_pulse", hit_pulse, 1);
    run_frames(60, 1'b0, 1'b0);
    check("revive2_state", state, 1);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hit3_lives", lives, 0);
    check("hit3_state", state, 2);
    run_frames(59, 1'b0, 1'b0);
    check("last_dying_state", state, 2);
    run_frames(1, 1'b0, 1'b0);
    check("over_state", state, 3);
    check("over_lives", lives, 0);
    run_frames(1, 1'b0, 1'b0);
    check("over_hold_state", state, 3);
    check("over_hold_frog_y", frog_y, 304);
    check("over_hold_score", score, 1);
    do_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("over_to_idle", state, 0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    check("restart_score", score, 0);

    // Async reset while the hit pulse is high, first DYING cycle.
    do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_rst_state", state, 2);
    check("pre_rst_pulse", hit_pulse, 1);
    #2;
    rst_pix = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_pulse", hit_pulse, 0);
    check("arst_lives", lives, 3);
    check("arst_score", score, 0);
    check("arst_frog_y", frog_y, 245);
    check("arst_obj3_x", ox(3), 350);
    check("arst_obj3_y", oy(3), -350);
    tick(); tick();
    rst_pix = 1'b0;
    lfsr_m = 9'h1FF;
    btn_start = 1'b1;
    tick(); tick(); tick();
    btn_start = 1'b0;
    check("post_rst_needs_frame", state, 0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_start", state, 1);

    // Score saturation: two respawns per frame, frame held high every cycle.
    sat_start = 1'b1;
    sat_frame = 1'b1;
    tick();
    sat_start = 1'b0;
    check("sat_start_state", s_state, 1);
    check("sat_start_score", s_score, 0);
    for (int i = 1; i <= 32770; i++) begin
      tick();
      if (i == 1)     check("sat_two_resp", s_score, 2);
      if (i == 2)     check("sat_four", s_score, 4);
      if (i == 32767) check("sat_below", s_score, 65534);
      if (i == 32768) check("sat_reach", s_score, 65535);
      if (i == 32770) check("sat_hold", s_score, 65535);
    end
    sat_frame = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
